// File: rtl/i2s_rx.sv
// i2s_rx: oversampled I2S slave receiver delivering left/right sample pairs on a valid/ready port
module i2s_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  clk1000,
  input  logic                  cpu_reset0,
  input  logic                  i2s_rx0_clk,
  input  logic                  i2s_rx0_sync,
  input  logic                  i2s_rx0_rx,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic [DATA_WIDTH-1:0] sample_right,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  frame_err
);
  localparam int CW = $clog2(SLOT_WIDTH + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(SLOT_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_WIDTH - 1);
  localparam logic [CW-1:0] CNT_DW = CW'(DATA_WIDTH);
  if (DATA_WIDTH > SLOT_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must not exceed SLOT_WIDTH");
  end
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
  state_t state, state_nxt;
  logic [1:0] rst_q;
  logic rst_n;
  logic [2:0] pin_s1, pin_s2;
  logic bclk_d, tick, ws_t, sd_t, ws_prev, ws_chg, len_ok;
  logic ld_left, pub, ferr;
  logic [CW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shreg, left_hold;
  always_ff @(posedge clk1000 or negedge cpu_reset0)
    if (!cpu_reset0) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_n = rst_q[1];
  // Pins go through two flops, then a registered rising-edge detect on bclk
  always_ff @(posedge clk1000 or negedge rst_n)
    if (!rst_n) begin
      pin_s1 <= '0;
      pin_s2 <= '0;
      bclk_d <= 1'b0;
      tick <= 1'b0;
      ws_t <= 1'b0;
      sd_t <= 1'b0;
    end else begin
      pin_s1 <= {i2s_rx0_clk, i2s_rx0_sync, i2s_rx0_rx};
      pin_s2 <= pin_s1;
      bclk_d <= pin_s2[2];
      tick <= pin_s2[2] & ~bclk_d;
      ws_t <= pin_s2[1];
      sd_t <= pin_s2[0];
    end
  assign ws_chg = tick && (ws_t != ws_prev);
  assign len_ok = bit_cnt == CNT_LAST;
  // The ws_chg tick carries the previous slot's LSB, so it never shifts in
  always_ff @(posedge clk1000 or negedge rst_n)
    if (!rst_n) begin
      ws_prev <= 1'b0;
      bit_cnt <= '0;
      shreg <= '0;
      left_hold <= '0;
    end else if (tick) begin
      ws_prev <= ws_t;
      bit_cnt <= ws_chg ? '0 : (bit_cnt == CNT_MAX ? bit_cnt : bit_cnt + 1'b1);
      if (!ws_chg && bit_cnt < CNT_DW) shreg <= {shreg[DATA_WIDTH-2:0], sd_t};
      if (ld_left) left_hold <= shreg;
    end
  always_ff @(posedge clk1000 or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    ld_left = 1'b0;
    pub = 1'b0;
    ferr = 1'b0;
    if (ws_chg)
      case (state)
        IDLE: state_nxt = ws_t ? IDLE : LEFT;
        LEFT: begin
          ld_left = len_ok;
          ferr = !len_ok;
          state_nxt = len_ok ? RIGHT : IDLE;
        end
        RIGHT: begin
          pub = len_ok;
          ferr = !len_ok;
          state_nxt = LEFT;
        end
        default: state_nxt = IDLE;
      endcase
  end
  // A completed pair only replaces the presented one if that is free or leaving this cycle
  always_ff @(posedge clk1000 or negedge rst_n)
    if (!rst_n) begin
      sample_left <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun <= pub && sample_valid && !sample_ready;
      frame_err <= ferr;
      if (pub && (!sample_valid || sample_ready)) begin
        sample_left <= left_hold;
        sample_right <= shreg;
        sample_valid <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed I2S frames into i2s_rx with hand-computed expected pairs and pulse counts
module tb_i2s_rx;
  localparam int HC = 50;
  localparam int HB = 1625;
  logic clk1000 = 1'b0;
  logic cpu_reset0 = 1'b0;
  logic i2s_rx0_clk = 1'b0;
  logic i2s_rx0_sync = 1'b0;
  logic i2s_rx0_rx = 1'b0;
  logic sample_ready = 1'b1;
  logic [23:0] sample_left, sample_right;
  logic sample_valid, overrun, frame_err;
  int n_vec = 0;
  int n_err = 0;
  int vcyc = 0;
  int n_ovr = 0;
  int n_fe = 0;
  int n_unstable = 0;
  logic held = 1'b0;
  logic [47:0] held_pair = '0;
  logic [47:0] got[$];
  int b_got, b_v, b_o, b_f, lat;
  logic [31:0] s;

  i2s_rx dut (
    .clk1000(clk1000),
    .cpu_reset0(cpu_reset0),
    .i2s_rx0_clk(i2s_rx0_clk),
    .i2s_rx0_sync(i2s_rx0_sync),
    .i2s_rx0_rx(i2s_rx0_rx),
    .sample_left(sample_left),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun(overrun),
    .frame_err(frame_err)
  );

  always #HC clk1000 = ~clk1000;

  always @(negedge clk1000)
    if (!cpu_reset0) held <= 1'b0;
    else begin
      if (sample_valid && sample_ready) got.push_back({sample_left, sample_right});
      if (sample_valid) vcyc <= vcyc + 1;
      if (overrun) n_ovr <= n_ovr + 1;
      if (frame_err) n_fe <= n_fe + 1;
      if (held && (!sample_valid || {sample_left, sample_right} != held_pair)) n_unstable <= n_unstable + 1;
      held <= sample_valid && !sample_ready;
      held_pair <= {sample_left, sample_right};
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [47:0] pair_at(input int i);
    return (i < got.size()) ? got[i] : 48'hEEEE_EEEE_EEEE;
  endfunction

  task automatic send_bit(input logic w, input logic d);
    i2s_rx0_clk = 1'b0;
    i2s_rx0_sync = w;
    i2s_rx0_rx = d;
    #HB;
    i2s_rx0_clk = 1'b1;
    #HB;
  endtask

  task automatic send_slot(input logic w, input logic [31:0] word, input int n);
    logic [31:0] sh;
    sh = word;
    for (int i = 0; i < n; i++) begin
      send_bit((i == n - 1) ? ~w : w, sh[31]);
      sh = sh << 1;
    end
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk1000);
    #10;
    sample_ready = v;
  endtask

  task automatic mark;
    b_got = got.size();
    b_v = vcyc;
    b_o = n_ovr;
    b_f = n_fe;
  endtask

  initial begin
    #1000;
    chk("reset_outs", {sample_valid, overrun, frame_err, sample_left, sample_right}, 64'h0);
    #1010;
    cpu_reset0 = 1'b1;
    #(HB * 2);
    // basic frames after a right-first lead-in
    mark();
    send_slot(1'b0, 32'h5A5A5A5A, 32);
    send_slot(1'b1, 32'hC3C3C3C3, 32);
    frame({24'h123456, 8'h00}, {24'hABCDEF, 8'h00});
    frame({24'h123456, 8'h00}, {24'hABCDEF, 8'h00});
    chk("t1_pairs", got.size() - b_got, 2);
    chk("t1_p0", pair_at(b_got), {24'h123456, 24'hABCDEF});
    chk("t1_p1", pair_at(b_got + 1), {24'h123456, 24'hABCDEF});
    chk("t1_vcyc", vcyc - b_v, 2);
    chk("t1_ovr", n_ovr - b_o, 0);
    chk("t1_fe", n_fe - b_f, 0);
    // extremes with trailing slot bits set
    mark();
    frame({24'h800000, 8'hFF}, {24'h7FFFFF, 8'hFF});
    chk("t2_pairs", got.size() - b_got, 1);
    chk("t2_p0", pair_at(b_got), {24'h800000, 24'h7FFFFF});
    // back-pressure for three frames
    mark();
    set_ready(1'b0);
    frame({24'h111111, 8'h00}, {24'h222222, 8'h00});
    frame({24'h333333, 8'h00}, {24'h444444, 8'h00});
    frame({24'h555555, 8'h00}, {24'h666666, 8'h00});
    chk("t3_ovr", n_ovr - b_o, 2);
    chk("t3_none", got.size() - b_got, 0);
    chk("t3_hold", {sample_valid, sample_left, sample_right}, {1'b1, 24'h111111, 24'h222222});
    chk("t3_stable", n_unstable, 0);
    set_ready(1'b1);
    frame({24'h777777, 8'h00}, {24'h888888, 8'h00});
    chk("t3_pairs", got.size() - b_got, 2);
    chk("t3_p0", pair_at(b_got), {24'h111111, 24'h222222});
    chk("t3_p1", pair_at(b_got + 1), {24'h777777, 24'h888888});
    // saturated left slot, then a short right slot
    mark();
    send_slot(1'b0, 32'hFFFFFFFF, 40);
    send_slot(1'b1, 32'h0F0F0F0F, 32);
    chk("t4_fe_left", n_fe - b_f, 1);
    frame({24'hC0FFEE, 8'h00}, {24'hBADC0D, 8'h00});
    frame({24'h999999, 8'h00}, {24'hAAAAAA, 8'h00});
    send_slot(1'b0, {24'h999999, 8'h00}, 32);
    send_slot(1'b1, {24'hAAAAAA, 8'h00}, 31);
    frame({24'h0A0B0C, 8'h00}, {24'h0D0E0F, 8'h00});
    chk("t4_fe", n_fe - b_f, 2);
    chk("t4_pairs", got.size() - b_got, 3);
    chk("t4_p0", pair_at(b_got), {24'hC0FFEE, 24'hBADC0D});
    chk("t4_p1", pair_at(b_got + 1), {24'h999999, 24'hAAAAAA});
    chk("t4_p2", pair_at(b_got + 2), {24'h0A0B0C, 24'h0D0E0F});
    // reset mid left slot with a pair held
    set_ready(1'b0);
    frame({24'h246802, 8'h00}, {24'h135791, 8'h00});
    chk("t6_valid_pre", sample_valid, 1);
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
    cpu_reset0 = 1'b0;
    #10;
    chk("t6_rst_outs", {sample_valid, overrun, frame_err, sample_left, sample_right}, 64'h0);
    #15;
    #(HB * 2);
    cpu_reset0 = 1'b1;
    set_ready(1'b1);
    // restart mid right slot, measure closing-edge latency
    mark();
    send_slot(1'b1, 32'hFFFF0000, 12);
    chk("t5_quiet", {sample_valid, 32'(got.size() - b_got)}, 0);
    send_slot(1'b0, {24'h2468AC, 8'h00}, 32);
    s = {24'h13579B, 8'h00};
    for (int i = 0; i < 31; i++) begin
      send_bit(1'b1, s[31]);
      s = s << 1;
    end
    i2s_rx0_clk = 1'b0;
    i2s_rx0_sync = 1'b0;
    i2s_rx0_rx = s[31];
    #HB;
    i2s_rx0_clk = 1'b1;
    fork
      #HB;
      begin
        lat = 0;
        do begin
          @(posedge clk1000);
          #10;
          lat++;
        end while (!sample_valid && lat < 15);
      end
    join
    chk("t5_latency", lat, 4);
    chk("t5_pairs", got.size() - b_got, 1);
    chk("t5_p0", pair_at(b_got), {24'h2468AC, 24'h13579B});
    chk("t5_fe", n_fe - b_f, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
